// File: rtl/sprite_dispatcher.sv
// Round-robin multi-channel sprite request front end for the blitter.
// Define DISPATCH_TIMEOUT_EN to build the blitter watchdog (sticky timeout_err).
module sprite_dispatcher #(
  parameter int unsigned CHANNELS       = 4,
  parameter int unsigned IDX_W          = 2,
  parameter int unsigned ADDR_W         = 26,
  parameter int unsigned SIZE_W         = 10,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  localparam int unsigned CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic [CHANNELS-1:0]          req_incoming,
  input  logic [CHANNELS*IDX_W-1:0]    req_sprite_num,
  output logic [CHANNELS-1:0]          req_received,
  output logic [CHANNELS-1:0]          req_finished,
  input  logic [CHANNELS-1:0]          req_ack_finished,
  output logic [IDX_W-1:0]             tbl_index,
  input  logic [ADDR_W+2*SIZE_W-1:0]   tbl_data,
  output logic                         blitter_start,
  input  logic                         blitter_finished,
  output logic [ADDR_W-1:0]            sprite_address,
  output logic [SIZE_W-1:0]            x_size,
  output logic [SIZE_W-1:0]            y_size,
  output logic [CH_W-1:0]              active_channel,
  output logic                         busy,
  output logic                         timeout_err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOOKUP  = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_START   = 3'd3;
  localparam logic [2:0] S_BLIT    = 3'd4;
  localparam logic [2:0] S_FINISH  = 3'd5;

  if (CHANNELS < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("sprite_dispatcher: CHANNELS and TIMEOUT_CYCLES must be at least 1");
  end

  logic [2:0]       state, next_state;
  logic [CH_W-1:0]  rr_ptr;
  logic             done_flag;
  logic             grant_valid;
  logic [CH_W-1:0]  grant_ch;
  logic             act_req, act_ack, done_now, timeout_hit;
  logic [IDX_W-1:0] sprite_num [CHANNELS];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_num
    assign sprite_num[c] = req_sprite_num[c*IDX_W +: IDX_W];
  end

  // (base + off) modulo CHANNELS; both operands are already below CHANNELS
  function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base, input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= CHANNELS) sum = sum - CHANNELS;
    return CH_W'(sum);
  endfunction

  function automatic logic [CHANNELS-1:0] onehot(input logic [CH_W-1:0] ch);
    return CHANNELS'(1) << ch;
  endfunction

  assign act_req  = req_incoming[active_channel];
  assign act_ack  = req_ack_finished[active_channel];
  assign done_now = done_flag | blitter_finished;

  // First pending request at or above rr_ptr, wrapping around
  always_comb begin
    grant_valid = 1'b0;
    grant_ch    = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (!grant_valid && req_incoming[wrap_add(rr_ptr, i)]) begin
        grant_valid = 1'b1;
        grant_ch    = wrap_add(rr_ptr, i);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (grant_valid) next_state = S_LOOKUP;
      S_LOOKUP:  next_state = S_CAPTURE;
      S_CAPTURE: next_state = S_START;
      S_START:   next_state = S_BLIT;
      S_BLIT:    if (done_now && !act_req) next_state = S_FINISH;
      S_FINISH:  if (act_ack) next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // Handshake, geometry and arbitration registers; status outputs track next_state
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rr_ptr         <= '0;
      active_channel <= '0;
      tbl_index      <= '0;
      sprite_address <= '0;
      x_size         <= '0;
      y_size         <= '0;
      done_flag      <= 1'b0;
      req_received   <= '0;
      req_finished   <= '0;
      blitter_start  <= 1'b0;
      busy           <= 1'b0;
    end else begin
      busy          <= (next_state != S_IDLE);
      blitter_start <= (next_state == S_START);
      req_finished  <= (next_state == S_FINISH) ? onehot(active_channel) : '0;
      case (state)
        S_IDLE: begin
          if (grant_valid) begin
            active_channel <= grant_ch;
            tbl_index      <= sprite_num[grant_ch];
            req_received   <= onehot(grant_ch);
          end
        end
        S_CAPTURE: {sprite_address, x_size, y_size} <= tbl_data;
        S_START:   done_flag <= blitter_finished;
        S_BLIT:    done_flag <= done_now | timeout_hit;
        S_FINISH:  if (act_ack) rr_ptr <= wrap_add(active_channel, 1);
        default:   ;
      endcase
      // Producer release is final for this transaction
      if (state != S_IDLE && !act_req) req_received <= '0;
    end
  end

`ifdef DISPATCH_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  assign timeout_hit = (state == S_BLIT) && !done_flag && (to_cnt == TO_W'(TIMEOUT_CYCLES));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == S_START)
        to_cnt <= '0;
      else if (state == S_BLIT && !done_flag && !timeout_hit)
        to_cnt <= to_cnt + 1'b1;
      if (timeout_hit) timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_dispatcher.sv
// Self-checking bench for sprite_dispatcher: transaction timeline model plus round-robin grant model.
`timescale 1ns/1ps
module tb_sprite_dispatcher;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int AW = 26;
  localparam int SW = 10;
  localparam int TW = AW + 2*SW;
  localparam int TO = 100;

  logic          Clk = 1'b0;
  logic          Reset;
  logic [N-1:0]  req_incoming, req_ack_finished, req_received, req_finished;
  logic [N*IW-1:0] req_sprite_num;
  logic [IW-1:0] tbl_index;
  logic [TW-1:0] tbl_data;
  logic          blitter_start, blitter_finished, busy, timeout_err;
  logic [AW-1:0] sprite_address;
  logic [SW-1:0] x_size, y_size;
  logic [1:0]    active_channel;

  logic [TW-1:0] tbl_mem [4];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int model_rr = 0;

  sprite_dispatcher #(
    .CHANNELS(N), .IDX_W(IW), .ADDR_W(AW), .SIZE_W(SW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .req_incoming(req_incoming), .req_sprite_num(req_sprite_num),
    .req_received(req_received), .req_finished(req_finished),
    .req_ack_finished(req_ack_finished),
    .tbl_index(tbl_index), .tbl_data(tbl_data),
    .blitter_start(blitter_start), .blitter_finished(blitter_finished),
    .sprite_address(sprite_address), .x_size(x_size), .y_size(y_size),
    .active_channel(active_channel), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 Clk = ~Clk;

  // External sprite table with one cycle of read latency
  always @(posedge Clk) begin
    cyc      <= cyc + 1;
    tbl_data <= tbl_mem[tbl_index];
  end

  task automatic raise(input int ch, input logic [IW-1:0] num);
    req_sprite_num[ch*IW +: IW] = num;
    req_incoming[ch] = 1'b1;
  endtask

  // One full transaction from an IDLE negedge; cycle 1 is the first cycle after the grant edge.
  task automatic run_txn(input int rel_c, input int fin_c, input int ack_dly,
                         input logic [N-1:0] late_req, input bit ack_probe,
                         output int got_ch, output int start_cyc);
    int exp_ch;
    int f;
    int a;
    logic [N-1:0]  oh;
    logic [IW-1:0] exp_num;
    logic [TW-1:0] geo;
    exp_ch = 0;
    for (int k = N - 1; k >= 0; k--)
      if (req_incoming[2'((model_rr + k) % N)]) exp_ch = (model_rr + k) % N;
    exp_num = req_sprite_num[exp_ch*IW +: IW];
    geo = tbl_mem[exp_num];
    oh = 4'(1) << exp_ch;
    f = (rel_c > fin_c) ? rel_c : fin_c;
    if (f < 4) f = 4;
    f = f + 1;
    a = f + ack_dly;
    got_ch = -1;
    start_cyc = -1;
    for (int t = 1; t <= a + 1; t++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (t == 1) begin
        got_ch = int'(active_channel);
        checks++;
        if (tbl_index !== exp_num)
          $display("FAIL tbl_index: got %0d expected %0d", tbl_index, exp_num);
        if (tbl_index !== exp_num) errors++;
      end
      if (t == 3) start_cyc = cyc;
      if (t <= a) begin
        checks++;
        if (busy !== 1'b1 || active_channel !== 2'(exp_ch)) begin
          errors++;
          $display("FAIL busy/active t=%0d: got busy=%b ch=%0d expected busy=1 ch=%0d", t, busy, active_channel, exp_ch);
        end
      end else begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL idle_after_ack: got busy=%b expected 0", busy);
        end
      end
      checks++;
      if (blitter_start !== (t == 3)) begin
        errors++;
        $display("FAIL blitter_start t=%0d: got %b expected %b", t, blitter_start, (t == 3));
      end
      if (t >= 3 && t <= a) begin
        checks++;
        if ({sprite_address, x_size, y_size} !== geo) begin
          errors++;
          $display("FAIL geometry t=%0d: got %h/%0d/%0d expected %h", t, sprite_address, x_size, y_size, geo);
        end
      end
      checks++;
      if (req_received !== ((t <= rel_c) ? oh : 4'b0)) begin
        errors++;
        $display("FAIL req_received t=%0d: got %b expected %b", t, req_received, (t <= rel_c) ? oh : 4'b0);
      end
      checks++;
      if (req_finished !== ((t >= f && t <= a) ? oh : 4'b0)) begin
        errors++;
        $display("FAIL req_finished t=%0d: got %b expected %b", t, req_finished, (t >= f && t <= a) ? oh : 4'b0);
      end
      if (t == rel_c) req_incoming[2'(exp_ch)] = 1'b0;
      if (t == 2) req_incoming = req_incoming | late_req;
      blitter_finished = (t == fin_c);
      req_ack_finished = 4'($urandom_range(0, 15)) & ~oh;
      if (t == a || (ack_probe && t == 2)) req_ack_finished[2'(exp_ch)] = 1'b1;
    end
    req_ack_finished = '0;
    blitter_finished = 1'b0;
    model_rr = (exp_ch + 1) % N;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    req_incoming = '0;
    req_sprite_num = '0;
    req_ack_finished = '0;
    blitter_finished = 1'b0;
    model_rr = 0;
    for (int i = 0; i < 4; i++) tbl_mem[i] = TW'(i * 3 + 1);
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    checks++;
    if ({busy, blitter_start, timeout_err, req_received, req_finished} !== 11'b0) begin
      errors++;
      $display("FAIL reset_status: got busy=%b start=%b to=%b rcv=%b fin=%b expected all 0",
               busy, blitter_start, timeout_err, req_received, req_finished);
    end
    checks++;
    if ({active_channel, tbl_index, sprite_address, x_size, y_size} !== 50'b0) begin
      errors++;
      $display("FAIL reset_regs: got ch=%0d idx=%0d addr=%h x=%0d y=%0d expected 0",
               active_channel, tbl_index, sprite_address, x_size, y_size);
    end
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_request: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    int got;
    int sc;
    for (int c = 0; c < N; c++) raise(c, 2'($urandom));
    for (int i = 0; i < 5; i++) begin
      run_txn(1, 3 + int'($urandom_range(0, 3)), 0, '0, 1'b0, got, sc);
      checks++;
      if (got !== order[i]) begin
        errors++;
        $display("FAIL rr_order[%0d]: got %0d expected %0d", i, got, order[i]);
      end
      raise(got, 2'($urandom));
    end
    req_incoming = '0;
  endtask

  task automatic test_single();
    int got;
    int sc;
    tbl_mem[3] = {26'h0001000, 10'd32, 10'd16};
    raise(2, 2'd3);
    run_txn(1, 23, 3, '0, 1'b0, got, sc);
    checks++;
    if (got !== 2) begin
      errors++;
      $display("FAIL single_channel: got %0d expected 2", got);
    end
  endtask

  task automatic test_early_finish();
    int got;
    int sc;
    raise(0, 2'($urandom));
    run_txn(13, 3, 1, '0, 1'b1, got, sc);
  endtask

  task automatic test_delayed_ack();
    int got;
    int sc;
    req_sprite_num[1*IW +: IW] = 2'd2;
    raise(0, 2'($urandom));
    run_txn(2, 6, 50, 4'b0010, 1'b0, got, sc);
    run_txn(1, 4, 0, '0, 1'b0, got, sc);
    checks++;
    if (got !== 1) begin
      errors++;
      $display("FAIL grant_after_ack: got %0d expected 1", got);
    end
  endtask

  task automatic test_back_to_back();
    int g1;
    int g2;
    int s1;
    int s2;
    raise(1, 2'($urandom));
    raise(3, 2'($urandom));
    run_txn(1, 3, 0, '0, 1'b0, g1, s1);
    run_txn(1, 3, 0, '0, 1'b0, g2, s2);
    checks++;
    if (s2 - s1 !== 6) begin
      errors++;
      $display("FAIL start_spacing: got %0d expected 6", s2 - s1);
    end
  endtask

  task automatic test_random();
    int got;
    int sc;
    for (int i = 0; i < 4; i++)
      tbl_mem[i] = {26'($urandom), 10'($urandom), 10'($urandom)};
    for (int n = 0; n < 25; n++) begin
      for (int c = 0; c < N; c++)
        if (!req_incoming[c] && $urandom_range(0, 1) == 1) raise(c, 2'($urandom));
      if (req_incoming == '0) raise(int'($urandom_range(0, N - 1)), 2'($urandom));
      run_txn(int'($urandom_range(1, 8)), int'($urandom_range(3, 12)),
              int'($urandom_range(0, 4)), '0, 1'($urandom), got, sc);
    end
    req_incoming = '0;
  endtask

  task automatic test_reset_mid_blit();
    int got;
    int sc;
    raise(0, 2'($urandom));
    run_txn(1, 3, 0, '0, 1'b0, got, sc);
    raise(1, 2'($urandom));
    repeat (8) @(posedge Clk);
    #2 Reset = 1'b1;
    #1;
    checks++;
    if ({busy, blitter_start, req_received, req_finished, active_channel, tbl_index} !== 14'b0 ||
        {sprite_address, x_size, y_size} !== 46'b0) begin
      errors++;
      $display("FAIL reset_mid_blit: got busy=%b start=%b rcv=%b fin=%b ch=%0d idx=%0d addr=%h expected all 0",
               busy, blitter_start, req_received, req_finished, active_channel, tbl_index, sprite_address);
    end
    req_incoming = '0;
    model_rr = 0;
    @(negedge Clk);
    Reset = 1'b0;
    blitter_finished = 1'b1;
    @(negedge Clk);
    blitter_finished = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      checks++;
      if (req_finished !== 4'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL stale_finish: got fin=%b busy=%b expected 0/0", req_finished, busy);
      end
    end
    raise(3, 2'($urandom));
    raise(0, 2'($urandom));
    run_txn(1, 3, 0, '0, 1'b0, got, sc);
    checks++;
    if (got !== 0) begin
      errors++;
      $display("FAIL rr_after_reset: got %0d expected 0", got);
    end
    req_incoming = '0;
  endtask

  task automatic test_watchdog();
    int fin_at;
    fin_at = -1;
    raise(2, 2'($urandom));
    for (int t = 1; t <= 200; t++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (t == 1) req_incoming[2] = 1'b0;
      if (fin_at < 0 && req_finished[2] === 1'b1) fin_at = t;
    end
`ifdef DISPATCH_TIMEOUT_EN
    checks++;
    if (fin_at < TO - 2 || fin_at > TO + 15) begin
      errors++;
      $display("FAIL watchdog_finish: got cycle %0d expected about %0d", fin_at, TO + 3);
    end
    req_ack_finished[2] = 1'b1;
    @(negedge Clk);
    req_ack_finished = '0;
    @(negedge Clk);
    checks++;
    if (timeout_err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL watchdog_sticky: got to=%b busy=%b expected 1/0", timeout_err, busy);
    end
`else
    checks++;
    if (fin_at !== -1 || busy !== 1'b1 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL no_watchdog: got fin_at=%0d busy=%b to=%b expected -1/1/0", fin_at, busy, timeout_err);
    end
`endif
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    model_rr = 0;
    @(negedge Clk);
    checks++;
    if (busy !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL watchdog_reset: got busy=%b to=%b expected 0/0", busy, timeout_err);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_early_finish();
    test_delayed_ack();
    test_back_to_back();
    test_random();
    test_reset_mid_blit();
    test_watchdog();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_dispatcher.md
# sprite_dispatcher

Multi-channel front end for the blitter. It accepts sprite draw requests from up to CHANNELS producers and arbitrates between them round-robin. For each granted request it looks up sprite geometry in an external one-cycle-latency sprite table, launches the blitter, and returns a per-channel received/finished handshake. It sits between the game-logic request sources and the blitter, as the parametrised multi-requester generation of the single-channel sprite communicator.

## Interface
Parameters:
- CHANNELS, 4, number of request channels (≥1)
- IDX_W, 2, sprite number width; table depth is 2**IDX_W
- ADDR_W, 26, sprite memory address width
- SIZE_W, 10, sprite x/y size width
- TIMEOUT_CYCLES, 65535, blitter watchdog limit (used only with the watchdog macro)
- CH_W, derived as max(1, $clog2(CHANNELS)), not overridden

Ports:
- Clk  in  1  clock, all logic on rising edge
- Reset  in  1  asynchronous, active-high
- req_incoming  in  CHANNELS  channel c requests; held high until req_received[c] is seen
- req_sprite_num  in  CHANNELS*IDX_W  sprite number, slice c = [c*IDX_W +: IDX_W]; stable while req_incoming[c]=1
- req_received  out  CHANNELS  request of channel c captured
- req_finished  out  CHANNELS  sprite of channel c fully drawn
- req_ack_finished  in  CHANNELS  channel c acknowledges req_finished[c]
- tbl_index  out  IDX_W  sprite table read index (registered)
- tbl_data  in  ADDR_W+2*SIZE_W  {address, x_size, y_size}; valid the cycle after tbl_index changes
- blitter_start  out  1  one-cycle launch pulse
- blitter_finished  in  1  blitter completion; pulse or level
- sprite_address  out  ADDR_W  registered sprite address for the blitter
- x_size, y_size  out  SIZE_W  registered sprite dimensions
- active_channel  out  CH_W  channel currently owning the blitter
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  sticky watchdog flag

## Operation
States: IDLE, LOOKUP, CAPTURE, START, BLIT, FINISH.
- **IDLE:** sample req_incoming. Grant the first set bit searching upward from rr_ptr, wrapping modulo CHANNELS.
  - On a grant: register active_channel and the matching req_sprite_num into tbl_index, then go to LOOKUP.
  - With no request pending: stay in IDLE.
- **LOOKUP:** tbl_index is presented to the table. Go to CAPTURE.
- **CAPTURE:** register tbl_data into sprite_address/x_size/y_size. Go to START.
- **START:** blitter_start=1 for exactly one cycle. Clear done_flag, then set it if blitter_finished is high in this same cycle. Go to BLIT.
- **BLIT:** done_flag is sticky; it is set by blitter_finished=1 in any cycle.
  - Go to FINISH when done_flag (or the current-cycle blitter_finished) is set and req_incoming[active_channel]=0.
  - Otherwise stay in BLIT.
- **FINISH:** req_finished[active_channel]=1.
  - On req_ack_finished[active_channel]=1: set rr_ptr = active_channel+1 (wrapping to 0 at CHANNELS) and go to IDLE.
  - Otherwise stay in FINISH.
- **req_received handshake:**
  - req_received[active_channel] is high from LOOKUP onward, in every state until req_incoming[active_channel] is seen low.
  - Once cleared it stays low for the rest of the transaction.
  - Only the active channel's bit can ever be high.
- **Ungranted channels:** requests on other channels wait; they are never dropped.
- **Early release:** once granted, a transaction always completes even if the producer drops req_incoming early.
- **Ignored ack bits:** req_ack_finished bits of inactive channels are ignored. So is req_ack_finished[active_channel] outside FINISH.
- **Output holds:** sprite_address/x_size/y_size hold their values until the next CAPTURE.
- **Reset** (at any time, including mid-BLIT):
  - Go to IDLE.
  - Clear rr_ptr, active_channel, tbl_index, sprite_address, x_size, y_size, done_flag, timeout counter and timeout_err.
  - Drive req_received, req_finished, blitter_start and busy to 0.
  - A blitter_finished arriving after reset is ignored.

## Timing
- **Grant to launch:** request seen in IDLE at cycle 0 → LOOKUP cycle 1 (req_received high) → CAPTURE cycle 2 → START cycle 3 (blitter_start high, geometry outputs valid).
- **Completion:** blitter_finished at cycle k, with the request already released → FINISH at k+1.
- **Acknowledge:** ack at cycle m in FINISH → IDLE at m+1 → the next grant takes effect at m+2 at the earliest.
- **Back-to-back:** minimum spacing between blitter_start pulses is 6 cycles.
- **Fairness:** with all channels requesting continuously, grants rotate 0,1,…,CHANNELS-1,0.
- **CHANNELS=1:** arbitration degenerates to channel 0 and rr_ptr stays 0.

## Configuration
- DISPATCH_TIMEOUT_EN defined:
  - A counter runs while in BLIT waiting on done_flag.
  - When it reaches TIMEOUT_CYCLES, done_flag is forced to 1 and timeout_err is set.
  - timeout_err stays set until Reset.
  - The counter clears in START.
- DISPATCH_TIMEOUT_EN undefined:
  - No counter is built; timeout_err is tied to 0.
  - BLIT waits indefinitely for blitter_finished.

## Test plan
- **Single request:** req_incoming[2]=1 with sprite 3, tbl_data = {26'h0001000, 10'd32, 10'd16}, producer releases after req_received, blitter_finished pulse 20 cycles after start.
  - tbl_index=3 at cycle 1.
  - blitter_start one-cycle pulse at cycle 3 with address 0x0001000, x_size 32, y_size 16.
  - active_channel=2.
  - req_finished[2] high until ack, then busy=0.
- **Round robin:** all 4 channels request continuously, each acked immediately → grant order 0,1,2,3,0; no channel is granted twice in a row.
- **Early finish:** blitter_finished asserted in the START cycle while the producer holds req_incoming 10 more cycles → stays in BLIT until release, then FINISH; done_flag not lost.
- **Delayed ack:** req_ack_finished held low for 50 cycles, with channel 1 requesting meanwhile → req_finished stays high and no grant is made to channel 1 until the ack.
- **Reset mid-BLIT:** Reset asserted 5 cycles after blitter_start → all outputs 0 in the same cycle and rr_ptr=0. A later blitter_finished does not produce req_finished.
- **Watchdog (DISPATCH_TIMEOUT_EN, TIMEOUT_CYCLES=100):** blitter_finished never asserted → FINISH entered about 100 cycles after START and timeout_err=1 until Reset. Without the macro, busy remains 1 indefinitely.
